// File: rtl/pipe_skid_buf.sv
// rtl/pipe_skid_buf.sv - elastic valid/ready pipeline stage with main + skid register
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   flush_i    in   synchronous flush (only when PIPE_SKID_FLUSH_EN is defined)
//   s_valid_i  in   upstream payload valid
//   s_ready_o  out  stage can accept (registered, = !skid_valid)
//   s_data_i   in   upstream payload [WIDTH-1:0]
//   m_valid_o  out  downstream payload valid (registered)
//   m_ready_i  in   downstream accepts
//   m_data_o   out  downstream payload, straight from the main register
//
// Build option: define PIPE_SKID_FLUSH_EN to add flush_i and the flush logic.

module pipe_skid_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic             flush_i,
`endif
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_data_o
);

  // Occupancy encoding is {skid_valid, main_valid}; skid never fills while
  // main is empty, so 2'b10 is unreachable.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic             main_valid;
  logic             skid_valid;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;

  logic       in_hs;
  logic       out_hs;
  logic       do_flush;
  logic [1:0] state;

  assign state     = {skid_valid, main_valid};
  assign m_valid_o = main_valid;
  assign m_data_o  = main_data;
  // Inverted flop output only: nothing from m_ready_i reaches s_ready_o.
  assign s_ready_o = ~skid_valid;

  assign in_hs  = s_valid_i & s_ready_o;
  assign out_hs = main_valid & m_ready_i;

`ifdef PIPE_SKID_FLUSH_EN
  assign do_flush = flush_i;
`else
  assign do_flush = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (do_flush) begin
      // Flush drops occupancy only; data registers keep their contents.
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_hs) begin
            main_valid <= 1'b1;
            main_data  <= s_data_i;
          end
        end
        ST_BUSY: begin
          if (in_hs && out_hs) begin
            main_data <= s_data_i;
          end else if (in_hs) begin
            // Downstream stalled: park the extra beat in skid.
            skid_valid <= 1'b1;
            skid_data  <= s_data_i;
          end else if (out_hs) begin
            main_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          // s_ready_o is low here, so only the output side can move.
          if (out_hs) begin
            main_data  <= skid_data;
            skid_valid <= 1'b0;
          end
        end
        default: begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
